mem_peripheral_bus: RTL

//  MEM-stage memory-mapped peripheral controller: timer, LEDs, switches, 7-seg digits, UART regs.

---
 rtl/peri_pkg.sv | 17 +
 rtl/peri_timer.sv | 32 +++
 rtl/mem_peripheral_bus.sv | 108 ++++++++++
 3 files changed

// File: rtl/peri_pkg.sv
// peri_pkg: shared register offsets and bit positions for the MEM-stage peripheral bus
package peri_pkg;
  localparam logic [7:0] OFF_TH     = 8'h00;
  localparam logic [7:0] OFF_TL     = 8'h04;
  localparam logic [7:0] OFF_TCON   = 8'h08;
  localparam logic [7:0] OFF_LED    = 8'h0C;
  localparam logic [7:0] OFF_SWITCH = 8'h10;
  localparam logic [7:0] OFF_DIGI   = 8'h14;
  localparam logic [7:0] OFF_TXD    = 8'h18;
  localparam logic [7:0] OFF_RXD    = 8'h1C;
  localparam logic [7:0] OFF_UCON   = 8'h20;
  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;
  localparam int UCON_TX_READY = 2;
  localparam int UCON_RX_READY = 3;
endpackage

// File: rtl/peri_timer.sv
// peri_timer: TH/TL/TCON timer with reload on overflow and a sticky interrupt flag
module peri_timer
  import peri_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wrTh,
  input  logic        wrTl,
  input  logic        wrTcon,
  input  logic [31:0] wrData,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  logic overflow;
  assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign irq = tcon[TCON_IE] & tcon[TCON_IRQ];
  // software writes win over counting; the overflow flag is ORed on top of a TCON write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wrTh) th <= wrData;
      if (wrTl) tl <= wrData;
      else if (tcon[TCON_EN]) tl <= overflow ? th : tl + 32'd1;
      tcon <= (wrTcon ? wrData[2:0] : tcon) | {overflow & tcon[TCON_IE], 2'b00};
    end
  end
endmodule

// File: rtl/mem_peripheral_bus.sv
// mem_peripheral_bus: MEM-stage decode for timer, LEDs, switches, 7-seg and UART registers
module mem_peripheral_bus
  import peri_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_data,
  input  logic             mem_wr,
  input  logic             mem_rd,
  output logic [31:0]      peri_rddata,
  output logic [31:0]      uart_data,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic [11:0]      digi,
  output logic             irq,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid
);
  logic            inWindow;
  logic [7:0]      offset;
  logic [31:0]     th, tl;
  logic [2:0]      tcon;
  logic [SW_W-1:0] swMeta, swSync;
  logic [7:0]      rxd;
  logic            rxReady;
  assign inWindow  = addr[31:8] == BASE_ADDR[31:8];
  assign offset    = addr[7:0] & 8'hFC;
  assign uart_data = {24'b0, rxd};
  peri_timer uTimer (
    .clk    (clk),
    .reset  (reset),
    .wrTh   (mem_wr && inWindow && offset == OFF_TH),
    .wrTl   (mem_wr && inWindow && offset == OFF_TL),
    .wrTcon (mem_wr && inWindow && offset == OFF_TCON),
    .wrData (wr_data),
    .th     (th),
    .tl     (tl),
    .tcon   (tcon),
    .irq    (irq)
  );
  // two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= switch;
      swSync <= swMeta;
    end
  end
  // LED and 7-seg output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (mem_wr && inWindow && offset == OFF_LED) led <= wr_data[LED_W-1:0];
      if (mem_wr && inWindow && offset == OFF_DIGI) digi <= wr_data[11:0];
    end
  end
  // TXD accepts a byte only when the transmitter is idle and pulses tx_start the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= mem_wr && inWindow && offset == OFF_TXD && !tx_busy;
      if (mem_wr && inWindow && offset == OFF_TXD && !tx_busy) tx_data <= wr_data[7:0];
    end
  end
  // a new byte always sets rx_ready, even when it coincides with the RXD load that clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd     <= '0;
      rxReady <= 1'b0;
    end else if (rx_valid) begin
      rxd     <= rx_data;
      rxReady <= 1'b1;
    end else if (mem_rd && inWindow && offset == OFF_RXD) begin
      rxReady <= 1'b0;
    end
  end
  // combinational read mux; unmapped or out-of-window addresses read 0
  always_comb begin
    peri_rddata = '0;
    if (inWindow) begin
      case (offset)
        OFF_TH:     peri_rddata = th;
        OFF_TL:     peri_rddata = tl;
        OFF_TCON:   peri_rddata = {29'b0, tcon};
        OFF_LED:    peri_rddata = 32'(led);
        OFF_SWITCH: peri_rddata = 32'(swSync);
        OFF_DIGI:   peri_rddata = {20'b0, digi};
        OFF_RXD:    peri_rddata = {24'b0, rxd};
        OFF_UCON:   peri_rddata = {28'b0, rxReady, ~tx_busy, 2'b00};
        default:    peri_rddata = '0;
      endcase
    end
  end
endmodule
